// File: rtl/adc_link_serializer_if.sv
// adc_link_serializer_if: sample-pair valid/ready handshake into the serializer
interface adc_link_serializer_if #(
    parameter int ADC_WIDHT = 14
);
    logic [ADC_WIDHT-1:0] DATA_IN1;
    logic [ADC_WIDHT-1:0] DATA_IN2;
    logic                 DATA_VALID;
    logic                 DATA_READY;
    modport master(output DATA_IN1, DATA_IN2, DATA_VALID, input DATA_READY);
    modport slave(input DATA_IN1, DATA_IN2, DATA_VALID, output DATA_READY);
endinterface

// File: rtl/adc_link_serializer.sv
// adc_link_serializer: two-lane MSB-first ADC-style serial link with DCO/FCO framing
module adc_link_serializer #(
    parameter int                   ADC_WIDHT    = 14,
    parameter logic [ADC_WIDHT-1:0] IDLE_PATTERN = ADC_WIDHT'(14'h2A5A)
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    TX_ENABLE,
    input  logic                    UNDERFLOW_CLR,
    adc_link_serializer_if.slave    link,
    output logic                    ADC_OUT1,
    output logic                    ADC_OUT2,
    output logic                    DCO,
    output logic                    FCO,
    output logic                    UNDERFLOW
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int            CW    = $clog2(ADC_WIDHT);
    localparam logic [CW-1:0] LAST  = CW'(ADC_WIDHT - 1);
    localparam logic [CW-1:0] FLAST = CW'(ADC_WIDHT / 2 - 1);
    state_t               state;
    logic [CW-1:0]        slot;
    logic [ADC_WIDHT-1:0] hold1, hold2, sh1, sh2, word1, word2;
    logic                 hold_full, frame_load, accept;
    always_comb begin
        frame_load      = TX_ENABLE && (state == IDLE || (state == RUN && slot == LAST));
        link.DATA_READY = !hold_full || frame_load;
        accept          = link.DATA_VALID && link.DATA_READY;
        word1           = hold_full ? hold1 : IDLE_PATTERN;
        word2           = hold_full ? hold2 : IDLE_PATTERN;
    end
    // ADC_OUTx is the bit currently on the wire; shN holds the bits still to go, MSB next
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            slot      <= '0;
            hold_full <= 1'b0;
            hold1     <= '0;
            hold2     <= '0;
            sh1       <= '0;
            sh2       <= '0;
            ADC_OUT1  <= 1'b0;
            ADC_OUT2  <= 1'b0;
            DCO       <= 1'b0;
            FCO       <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (accept) begin
                hold1 <= link.DATA_IN1;
                hold2 <= link.DATA_IN2;
            end
            hold_full <= accept || (hold_full && !frame_load);
            UNDERFLOW <= (frame_load && !hold_full) || (UNDERFLOW && !UNDERFLOW_CLR);
            if (frame_load) begin
                state           <= RUN;
                slot            <= '0;
                {ADC_OUT1, sh1} <= {word1, 1'b0};
                {ADC_OUT2, sh2} <= {word2, 1'b0};
                DCO             <= 1'b0;
                FCO             <= 1'b1;
            end else if (state == RUN && slot != LAST) begin
                slot            <= slot + 1'b1;
                {ADC_OUT1, sh1} <= {sh1, 1'b0};
                {ADC_OUT2, sh2} <= {sh2, 1'b0};
                DCO             <= ~DCO;
                FCO             <= slot < FLAST;
            end else begin
                state    <= IDLE;
                slot     <= '0;
                sh1      <= '0;
                sh2      <= '0;
                ADC_OUT1 <= 1'b0;
                ADC_OUT2 <= 1'b0;
                DCO      <= 1'b0;
                FCO      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_link_serializer.sv
// tb_adc_link_serializer: randomized scoreboard bench for adc_link_serializer
`timescale 1ns/1ps
module tb_adc_link_serializer;
    localparam int         W      = 14;
    localparam logic [W-1:0] IDLE_W = 14'h2A5A;

    logic CLK = 1'b0, RESET_N = 1'b0, TX_ENABLE = 1'b0, UNDERFLOW_CLR = 1'b0;
    logic ADC_OUT1, ADC_OUT2, DCO, FCO, UNDERFLOW;
    int   checks = 0, errors = 0, to_cnt = 0;
    logic done_req = 1'b0, done_ack = 1'b0;

    adc_link_serializer_if #(.ADC_WIDHT(W)) bus();

    adc_link_serializer #(.ADC_WIDHT(W), .IDLE_PATTERN(IDLE_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .TX_ENABLE(TX_ENABLE), .UNDERFLOW_CLR(UNDERFLOW_CLR),
        .link(bus.slave), .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2), .DCO(DCO), .FCO(FCO),
        .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // reference model: frame position, one-deep buffer, queue of words due on the wire
    logic m_run = 1'b0, m_full = 1'b0, m_uf = 1'b0, m_rst = 1'b0, m_ready, m_load;
    int   m_pos = 0;
    logic [W-1:0]   m_b1 = '0, m_b2 = '0;
    logic [2*W-1:0] exp_q[$];

    always_comb begin
        m_load  = TX_ENABLE && (!m_run || m_pos == W - 1);
        m_ready = !m_full || m_load;
    end

    always @(posedge CLK) begin
        m_rst <= !RESET_N;
        if (!RESET_N) begin
            m_run  <= 1'b0;
            m_pos  <= 0;
            m_full <= 1'b0;
            m_uf   <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_load) exp_q.push_back(m_full ? {m_b1, m_b2} : {IDLE_W, IDLE_W});
            m_uf  <= (m_load && !m_full) || (m_uf && !UNDERFLOW_CLR);
            m_run <= m_load || (m_run && m_pos < W - 1);
            m_pos <= (!m_load && m_run && m_pos < W - 1) ? m_pos + 1 : 0;
            if (bus.DATA_VALID && m_ready) begin
                m_b1   <= bus.DATA_IN1;
                m_b2   <= bus.DATA_IN2;
                m_full <= 1'b1;
            end else if (m_load) begin
                m_full <= 1'b0;
            end
        end
    end

    // monitor: frames are framed by the DUT's own FCO rising edge
    int             k = -1;
    logic           fco_q = 1'b0;
    logic [W-1:0]   g1 = '0, g2 = '0;
    logic [2*W-1:0] e;

    always @(negedge CLK) begin
        checks++;
        if (bus.DATA_READY !== m_ready) begin
            errors++;
            $display("FAIL ready t=%0t got=%b want=%b", $time, bus.DATA_READY, m_ready);
        end
        checks++;
        if (UNDERFLOW !== m_uf) begin
            errors++;
            $display("FAIL underflow t=%0t got=%b want=%b", $time, UNDERFLOW, m_uf);
        end
        if (!m_run) begin
            checks++;
            if ({ADC_OUT1, ADC_OUT2, DCO, FCO} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_outputs t=%0t got=%b want=0000", $time, {ADC_OUT1, ADC_OUT2, DCO, FCO});
            end
        end
        if (m_rst) begin
            checks++;
            if ({ADC_OUT1, ADC_OUT2, DCO, FCO, UNDERFLOW, bus.DATA_READY} !== 6'b000001) begin
                errors++;
                $display("FAIL after_reset t=%0t got=%b want=000001", $time,
                         {ADC_OUT1, ADC_OUT2, DCO, FCO, UNDERFLOW, bus.DATA_READY});
            end
        end
        if (!RESET_N) begin
            k = -1;
        end else begin
            if (k < 0 && FCO === 1'b1 && !fco_q) begin
                k  = 0;
                g1 = '0;
                g2 = '0;
            end
            if (k >= 0) begin
                checks++;
                if (DCO !== ((k % 2) != 0) || FCO !== (k < W / 2)) begin
                    errors++;
                    $display("FAIL clocks t=%0t slot=%0d got dco=%b fco=%b want dco=%b fco=%b", $time, k,
                             DCO, FCO, (k % 2) != 0, k < W / 2);
                end
                g1 = {g1[W-2:0], ADC_OUT1};
                g2 = {g2[W-2:0], ADC_OUT2};
                k++;
                if (k == W) begin
                    k = -1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame t=%0t got=%h/%h want=no frame", $time, g1, g2);
                    end else begin
                        e = exp_q.pop_front();
                        if ({g1, g2} !== e) begin
                            errors++;
                            $display("FAIL frame t=%0t got=%h/%h want=%h/%h", $time, g1, g2,
                                     e[2*W-1:W], e[W-1:0]);
                        end
                    end
                end
            end
        end
        fco_q = FCO;
        if (done_req && !done_ack) begin
            checks++;
            if (exp_q.size() != 0 || k >= 0) begin
                errors++;
                $display("FAIL drain got pending=%0d slot=%0d want pending=0 slot=-1", exp_q.size(), k);
            end
            checks++;
            if (to_cnt != 0) begin
                errors++;
                $display("FAIL timeouts got=%0d want=0", to_cnt);
            end
            done_ack = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int t = 0;
        while (!(m_run && m_pos == p) && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) begin
            to_cnt++;
            $display("FAIL wait_slot got run=%b pos=%0d want slot %0d", m_run, m_pos, p);
        end
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN1   = a;
        bus.DATA_IN2   = b;
        tick();
        bus.DATA_VALID = 1'b0;
    endtask

    initial begin
        bus.DATA_VALID = 1'b0;
        bus.DATA_IN1   = '0;
        bus.DATA_IN2   = '0;
        tick(3);
        RESET_N = 1'b1;
        tick(2);
        offer(14'h3FFF, 14'h0001);
        TX_ENABLE = 1'b1;
        tick();
        TX_ENABLE = 1'b0;
        tick(30);
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN1   = 14'h1555;
        bus.DATA_IN2   = 14'h2AAA;
        tick(2);
        TX_ENABLE = 1'b1;
        tick(5 * W);
        TX_ENABLE      = 1'b0;
        bus.DATA_VALID = 1'b0;
        tick(30);
        RESET_N = 1'b0;
        tick();
        RESET_N   = 1'b1;
        TX_ENABLE = 1'b1;
        tick(2 * W);
        TX_ENABLE = 1'b0;
        tick(20);
        UNDERFLOW_CLR = 1'b1;
        tick();
        UNDERFLOW_CLR = 1'b0;
        tick(3);
        offer(14'h1234, 14'h0ABC);
        TX_ENABLE = 1'b1;
        tick();
        wait_pos(1);
        offer(14'h2F0F, 14'h10F0);
        wait_pos(3);
        TX_ENABLE = 1'b0;
        tick(30);
        TX_ENABLE = 1'b1;
        tick();
        TX_ENABLE = 1'b0;
        tick(30);
        offer(14'h0FFF, 14'h3000);
        TX_ENABLE = 1'b1;
        wait_pos(5);
        RESET_N = 1'b0;
        tick();
        RESET_N   = 1'b1;
        TX_ENABLE = 1'b0;
        tick(5);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) TX_ENABLE = ~TX_ENABLE;
            bus.DATA_VALID = 1'($urandom_range(1));
            bus.DATA_IN1   = W'($urandom);
            bus.DATA_IN2   = W'($urandom);
            UNDERFLOW_CLR  = ($urandom_range(40) == 0);
            RESET_N        = ($urandom_range(600) != 0);
            tick();
        end
        RESET_N        = 1'b1;
        TX_ENABLE      = 1'b0;
        bus.DATA_VALID = 1'b0;
        UNDERFLOW_CLR  = 1'b0;
        tick(40);
        done_req = 1'b1;
        for (int i = 0; i < 10 && !done_ack; i++) tick();
        if (!done_ack) begin
            errors++;
            $display("FAIL final_check got=not run want=run");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
